// File: rtl/clk_enable_gen_if.sv
// rtl/clk_enable_gen_if.sv - configuration request/accept bundle for clk_enable_gen
interface clk_enable_gen_if #(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 16
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [DIV_WIDTH-1:0] cfg_div;
  logic [DIV_WIDTH-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_chan, cfg_div, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - lock-qualified multi-channel clock-enable generator
module clk_enable_gen #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pll_locked,
  clk_enable_gen_if.slave     cfg,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] sq,
  output logic                locked
);
  localparam int SET_W = $clog2(LOCK_CYCLES);
  localparam logic [DIV_WIDTH:0] ONE_X = 1;

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t               state_q, state_d;
  logic                 lock_meta, lock_sync;
  logic [SET_W-1:0]     settle_cnt;
  logic                 run_enter;
  logic                 accept;

  logic [DIV_WIDTH-1:0] div_q    [CHANNELS];
  logic [DIV_WIDTH-1:0] phase_q  [CHANNELS];
  logic [DIV_WIDTH-1:0] cnt_q    [CHANNELS];
  logic [DIV_WIDTH-1:0] sh_div   [CHANNELS];
  logic [DIV_WIDTH-1:0] sh_phase [CHANNELS];
  logic [DIV_WIDTH:0]   half     [CHANNELS];
  logic [CHANNELS-1:0]  pend_q, wrap, apply;

  // two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // lock FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= WAIT_LOCK;
    else       state_q <= state_d;
  end

  // lock FSM next state: any lost sample drops back to waiting
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lock_sync) state_d = SETTLE;
      SETTLE: begin
        if (!lock_sync)                                  state_d = WAIT_LOCK;
        else if (settle_cnt == SET_W'(LOCK_CYCLES - 1)) state_d = RUN;
      end
      RUN:     if (!lock_sync) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // lock FSM outputs: stable-lock flag and the re-phase strobe
  always_comb begin
    locked    = (state_q == RUN);
    run_enter = (state_d == RUN) && (state_q != RUN);
  end

  // settle counter runs only while in SETTLE, so it is zero on entry
  always_ff @(posedge clock) begin
    if (reset || state_q != SETTLE) settle_cnt <= '0;
    else                            settle_cnt <= settle_cnt + SET_W'(1);
  end

  // accept is refused only for an in-range channel that still holds a pending write
  always_comb begin
    cfg.cfg_ready = 1'b0;
    if (!reset) begin
      if (int'(cfg.cfg_chan) >= CHANNELS) cfg.cfg_ready = 1'b1;
      else                                cfg.cfg_ready = !pend_q[cfg.cfg_chan];
    end
    accept = cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_chan) < CHANNELS);
  end

  // per-channel decodes; a running channel swaps config only on its own wrap
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      half[i]  = ({1'b0, div_q[i]} + ONE_X) >> 1;
      wrap[i]  = (cnt_q[i] == div_q[i] - DIV_WIDTH'(1));
      ce[i]    = locked && (div_q[i] != '0) && wrap[i];
      sq[i]    = locked && (div_q[i] != '0) && ({1'b0, cnt_q[i]} < half[i]);
      apply[i] = pend_q[i] && (!(locked && (div_q[i] != '0)) || wrap[i]);
    end
  end

  // channel counters, live config and shadow config
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]    <= DIV_WIDTH'(DEFAULT_DIV);
        phase_q[i]  <= '0;
        cnt_q[i]    <= '0;
        sh_div[i]   <= '0;
        sh_phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (apply[i]) begin
          div_q[i]   <= sh_div[i];
          phase_q[i] <= sh_phase[i];
          cnt_q[i]   <= (sh_div[i] == '0) ? '0 : sh_phase[i];
          pend_q[i]  <= 1'b0;
        end else if (run_enter) begin
          cnt_q[i] <= (div_q[i] == '0) ? '0 : phase_q[i];
        end else if (locked && (div_q[i] != '0)) begin
          cnt_q[i] <= wrap[i] ? '0 : cnt_q[i] + DIV_WIDTH'(1);
        end
        if (accept && (int'(cfg.cfg_chan) == i)) begin
          sh_div[i]   <= cfg.cfg_div;
          sh_phase[i] <= ((cfg.cfg_div != '0) && (cfg.cfg_phase >= cfg.cfg_div)) ? '0 : cfg.cfg_phase;
          pend_q[i]   <= 1'b1;
        end
      end
    end
  end
endmodule
